// File: rtl/kernel_ctrl_pkg.sv
// Shared definitions for the expand-stage kernel bank controller.
//   - buf_state_e : life cycle of one ping-pong layer buffer
//   - DEF_*       : default parameter values
//   - cfg_err()   : legality check for a layer configuration
package kernel_ctrl_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2,
    BUF_READING = 2'd3
  } buf_state_e;

  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_KER_W     = 72;
  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_DEPTH_W   = 6;
  localparam int DEF_DIM_W     = 7;

  // A layer is illegal if no banks, too many banks, no kernel groups, or
  // more words per bank than one buffer half holds.
  function automatic logic cfg_err(input int unsigned act, input int unsigned nb,
                                   input int unsigned lim, input int unsigned wpb,
                                   input int unsigned cap);
    return (act == 0) || (act > nb) || (lim == 0) || (wpb > cap);
  endfunction

endpackage

// File: rtl/kernel_bank_ram.sv
// One kernel bank: simple dual-port RAM, 2^(ADDR_W+1) x KER_W.
// Address MSB selects the ping-pong buffer half.
//   wr_en_i/wr_addr_i/wr_data_i : write port, lands on the clock edge
//   rd_en_i/rd_addr_i           : read port
//   rd_data_o                   : registered read data, valid the cycle after rd_en_i
module kernel_bank_ram #(
  parameter int KER_W  = 72,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   wr_addr_i,
  input  logic [KER_W-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W:0]   rd_addr_i,
  output logic [KER_W-1:0]  rd_data_o
);

  logic [KER_W-1:0] mem_q [2**(ADDR_W+1)];
  logic [KER_W-1:0] rd_data_q;

  // Storage only; no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/kernel_bank_controller.sv
// Double-buffered kernel store. Kernel words stream in over wr_valid/ready
// and are dealt round-robin over the active banks; a full layer buffer is
// replayed to the MAC array as depth (inner), pixel, group (outer) beats.
//   start_i + config inputs : latch layer config, abort and empty everything
//   wr_*                    : kernel word input stream
//   kerl_req_i/ready/valid  : read beat handshake, data 1 cycle after accept
//   kerl_data_o             : bank b at [b*KER_W +: KER_W], inactive banks 0
//   busy_o / err_o          : legal config running / sticky config error
module kernel_bank_controller
  import kernel_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int KER_W     = DEF_KER_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH_W   = DEF_DEPTH_W,
  parameter int DIM_W     = DEF_DIM_W,
  localparam int AB_W     = $clog2(NUM_BANKS) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          ker_addr_limit_i,
  input  logic [DEPTH_W-1:0]         ker_depth_i,
  input  logic [DIM_W-1:0]           layer_dimension_i,
  input  logic [AB_W-1:0]            active_banks_i,
  input  logic [KER_W-1:0]           wr_data_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic                       kerl_req_i,
  output logic                       kerl_ready_o,
  output logic                       kerl_valid_o,
  output logic [NUM_BANKS*KER_W-1:0] kerl_data_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int WPB_W = ADDR_W + DEPTH_W + 1;

  logic [ADDR_W-1:0]  limit_q, limit_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DIM_W-1:0]   dim_q, dim_d;
  logic [AB_W-1:0]    active_q, active_d;
  logic [WPB_W-1:0]   wpb_q, wpb_d;
  logic               busy_q, busy_d, err_q, err_d;
  logic               wen_q, wen_d;     // write side enabled, one cycle after busy
  buf_state_e         buf_q [2];
  buf_state_e         buf_d [2];
  logic               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AB_W-1:0]    wbank_q, wbank_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DEPTH_W-1:0] d_q, d_d;
  logic [DIM_W-1:0]   p_q, p_d;
  logic [ADDR_W-1:0]  g_q, g_d, base_q, base_d;
  logic               vld_q, vld_d;

  logic [WPB_W-1:0]   wpb_in;
  logic               cfg_bad, wr_fire, wr_last, rd_fire, d_last, p_last, g_last;
  logic [ADDR_W-1:0]  rd_addr;
  logic [KER_W-1:0]   rd_data [NUM_BANKS];

  assign wpb_in  = WPB_W'(ker_addr_limit_i) * (WPB_W'(ker_depth_i) + WPB_W'(1));
  assign cfg_bad = cfg_err(32'(active_banks_i), 32'(NUM_BANKS), 32'(ker_addr_limit_i),
                           32'(wpb_in), 32'(2**ADDR_W));

  assign wr_ready_o   = wen_q && (buf_q[wptr_q] == BUF_EMPTY || buf_q[wptr_q] == BUF_FILLING);
  assign kerl_ready_o = buf_q[rptr_q] == BUF_FULL || buf_q[rptr_q] == BUF_READING;
  assign wr_fire      = wr_valid_i && wr_ready_o;
  assign rd_fire      = kerl_req_i && kerl_ready_o;
  assign wr_last      = (wbank_q == active_q - AB_W'(1)) &&
                        (WPB_W'(waddr_q) == wpb_q - WPB_W'(1));
  assign d_last       = d_q == depth_q;
  assign p_last       = p_q == dim_q;
  assign g_last       = g_q == limit_q - ADDR_W'(1);
  // Group base advances by depth+1 per group, so no multiplier here.
  assign rd_addr      = base_q + ADDR_W'(d_q);

  always_comb begin
    limit_d = limit_q; depth_d = depth_q; dim_d = dim_q; active_d = active_q;
    wpb_d = wpb_q; busy_d = busy_q; err_d = err_q; wen_d = busy_q;
    buf_d = buf_q; wptr_d = wptr_q; rptr_d = rptr_q;
    wbank_d = wbank_q; waddr_d = waddr_q;
    d_d = d_q; p_d = p_q; g_d = g_q; base_d = base_q;
    vld_d = rd_fire;
    if (start_i) begin
      limit_d = ker_addr_limit_i; depth_d = ker_depth_i; dim_d = layer_dimension_i;
      active_d = active_banks_i; wpb_d = wpb_in;
      busy_d = !cfg_bad; err_d = cfg_bad; wen_d = 1'b0;
      buf_d[0] = BUF_EMPTY; buf_d[1] = BUF_EMPTY;
      wptr_d = 1'b0; rptr_d = 1'b0;
      wbank_d = '0; waddr_d = '0;
      d_d = '0; p_d = '0; g_d = '0; base_d = '0;
      vld_d = 1'b0;  // drop any beat accepted on the abort edge
    end else begin
      // Write and read never target the same buffer: their state sets are disjoint.
      if (wr_fire) begin
        if (wr_last) begin
          buf_d[wptr_q] = BUF_FULL;
          wptr_d = !wptr_q; wbank_d = '0; waddr_d = '0;
        end else begin
          buf_d[wptr_q] = BUF_FILLING;
          if (wbank_q == active_q - AB_W'(1)) begin
            wbank_d = '0; waddr_d = waddr_q + ADDR_W'(1);
          end else begin
            wbank_d = wbank_q + AB_W'(1);
          end
        end
      end
      if (rd_fire) begin
        buf_d[rptr_q] = BUF_READING;
        if (d_last && p_last && g_last) begin
          buf_d[rptr_q] = BUF_EMPTY;
          rptr_d = !rptr_q;
          d_d = '0; p_d = '0; g_d = '0; base_d = '0;
        end else if (d_last) begin
          d_d = '0;
          if (p_last) begin
            p_d = '0; g_d = g_q + ADDR_W'(1);
            base_d = base_q + ADDR_W'(depth_q) + ADDR_W'(1);
          end else begin
            p_d = p_q + DIM_W'(1);
          end
        end else begin
          d_d = d_q + DEPTH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      limit_q <= '0; depth_q <= '0; dim_q <= '0; active_q <= '0; wpb_q <= '0;
      busy_q <= 1'b0; err_q <= 1'b0; wen_q <= 1'b0;
      buf_q[0] <= BUF_EMPTY; buf_q[1] <= BUF_EMPTY;
      wptr_q <= 1'b0; rptr_q <= 1'b0; wbank_q <= '0; waddr_q <= '0;
      d_q <= '0; p_q <= '0; g_q <= '0; base_q <= '0; vld_q <= 1'b0;
    end else begin
      limit_q <= limit_d; depth_q <= depth_d; dim_q <= dim_d; active_q <= active_d;
      wpb_q <= wpb_d; busy_q <= busy_d; err_q <= err_d; wen_q <= wen_d;
      buf_q <= buf_d; wptr_q <= wptr_d; rptr_q <= rptr_d;
      wbank_q <= wbank_d; waddr_q <= waddr_d;
      d_q <= d_d; p_q <= p_d; g_q <= g_d; base_q <= base_d; vld_q <= vld_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    kernel_bank_ram #(.KER_W(KER_W), .ADDR_W(ADDR_W)) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (wr_fire && wbank_q == AB_W'(b)),
      .wr_addr_i ({wptr_q, waddr_q}),
      .wr_data_i (wr_data_i),
      .rd_en_i   (rd_fire),
      .rd_addr_i ({rptr_q, rd_addr}),
      .rd_data_o (rd_data[b])
    );
    // Gating by valid also keeps the bus at zero out of reset.
    assign kerl_data_o[b*KER_W +: KER_W] =
      (vld_q && AB_W'(b) < active_q) ? rd_data[b] : '0;
  end

  assign kerl_valid_o = vld_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_kernel_bank_controller.sv
module tb_kernel_bank_controller;
  localparam int NB = 4, KW = 72, AW = 7, DW = 6, MW = 7, ABW = 3;
  typedef logic [NB*KW-1:0] beat_t;

  logic clk = 0, rst = 1, start_i = 0, wr_valid_i = 0, kerl_req_i = 0;
  logic [AW-1:0] lim_i = 0; logic [DW-1:0] dep_i = 0; logic [MW-1:0] dim_i = 0;
  logic [ABW-1:0] act_i = 0; logic [KW-1:0] wr_data_i = 0;
  logic wr_ready_o, kerl_ready_o, kerl_valid_o, busy_o, err_o;
  beat_t kerl_data_o;

  kernel_bank_controller #(.NUM_BANKS(NB), .KER_W(KW), .ADDR_W(AW), .DEPTH_W(DW), .DIM_W(MW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .ker_addr_limit_i(lim_i),
    .ker_depth_i(dep_i), .layer_dimension_i(dim_i), .active_banks_i(act_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .kerl_req_i(kerl_req_i), .kerl_ready_o(kerl_ready_o), .kerl_valid_o(kerl_valid_o),
    .kerl_data_o(kerl_data_o), .busy_o(busy_o), .err_o(err_o));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: the layer as a flat list of accepted words plus counts.
  int c_lim, c_dep, c_dim, c_act, wpl, bpl;
  int wcnt, rcnt, vcnt;
  bit mon_en = 0, exp_valid = 0;
  logic [KW-1:0] wq[$];
  beat_t got[$];
  int got_cyc[$];

  task automatic chk(input string nm, input beat_t a, input beat_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic beat_t exp_beat(input int j);
    beat_t r = '0;
    int layer = j / bpl, i = j % bpl;
    int g = i / ((c_dim + 1) * (c_dep + 1)), d = i % (c_dep + 1);
    int addr = g * (c_dep + 1) + d;
    for (int b = 0; b < c_act; b++) r[b*KW +: KW] = wq[layer*wpl + addr*c_act + b];
    return r;
  endfunction

  function automatic beat_t mk4(input int a3, input int a2, input int a1, input int a0);
    return {KW'(a3), KW'(a2), KW'(a1), KW'(a0)};
  endfunction

  // Compare process: outputs vs model, then commit this cycle's handshakes.
  always @(negedge clk) begin
    int fl, dl; bit ewr, ekr;
    if (mon_en) begin
      fl = wcnt / wpl; dl = rcnt / bpl;
      ewr = (fl - dl) < 2;
      ekr = rcnt < fl * bpl;
      chk("wr_ready", beat_t'(wr_ready_o), beat_t'(ewr));
      chk("kerl_ready", beat_t'(kerl_ready_o), beat_t'(ekr));
      chk("kerl_valid", beat_t'(kerl_valid_o), beat_t'(exp_valid));
      chk("busy", beat_t'(busy_o), beat_t'(1));
      chk("err", beat_t'(err_o), beat_t'(0));
      if (kerl_valid_o && vcnt < rcnt) begin
        chk("beat_data", kerl_data_o, exp_beat(vcnt));
        got.push_back(kerl_data_o); got_cyc.push_back(cyc);
        vcnt++;
      end
      exp_valid = kerl_req_i && ekr;
      if (exp_valid) rcnt++;
      if (wr_valid_i && ewr) begin wq.push_back(wr_data_i); wcnt++; end
    end
  end

  task automatic start_cfg(input int l, input int d, input int m, input int a);
    @(posedge clk); #1;
    start_i = 1; lim_i = AW'(l); dep_i = DW'(d); dim_i = MW'(m); act_i = ABW'(a);
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic do_start(input int l, input int d, input int m, input int a);
    mon_en = 0;
    start_cfg(l, d, m, a);
    c_lim = l; c_dep = d; c_dim = m; c_act = a;
    wpl = l * (d + 1) * a; bpl = l * (m + 1) * (d + 1);
    wq.delete(); got.delete(); got_cyc.delete();
    wcnt = 0; rcnt = 0; vcnt = 0; exp_valid = 0;
    @(posedge clk); #1;
    mon_en = 1;
  endtask

  task automatic run(input int nlay, input int nbeats, input int wp, input int rp,
                     input bit seq, input int base);
    int tot = nlay * wpl, k;
    for (k = 0; k < 20000; k++) begin
      if (wcnt >= tot && vcnt >= nbeats) break;
      wr_valid_i = (wcnt < tot) && ($urandom_range(99) < wp);
      wr_data_i  = seq ? KW'(base + wcnt) : KW'({$urandom(), $urandom(), $urandom()});
      kerl_req_i = $urandom_range(99) < rp;
      @(posedge clk); #1;
    end
    wr_valid_i = 0; kerl_req_i = 0;
    n_tests++;
    if (k >= 20000) begin n_fail++; $display("FAIL run_timeout: got %0d beats expected %0d", vcnt, nbeats); end
  endtask

  initial begin
    int ord[12] = '{0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3};
    #1;
    chk("rst_wr_ready", beat_t'(wr_ready_o), '0);
    chk("rst_kerl_ready", beat_t'(kerl_ready_o), '0);
    chk("rst_kerl_valid", beat_t'(kerl_valid_o), '0);
    chk("rst_busy", beat_t'(busy_o), '0);
    chk("rst_err", beat_t'(err_o), '0);
    chk("rst_data", kerl_data_o, '0);
    @(posedge clk); #1 rst = 0;

    // Basic
    do_start(2, 1, 0, 4);
    run(1, 4, 100, 100, 1, 0);
    chk("basic_n", beat_t'(got.size()), beat_t'(4));
    chk("basic_b0", got[0], mk4(3, 2, 1, 0));
    chk("basic_b1", got[1], mk4(7, 6, 5, 4));
    chk("basic_b2", got[2], mk4(11, 10, 9, 8));
    chk("basic_b3", got[3], mk4(15, 14, 13, 12));
    chk("basic_ready_drop", beat_t'(kerl_ready_o), '0);

    // Replay
    do_start(2, 1, 2, 4);
    run(1, 12, 100, 100, 1, 0);
    chk("replay_n", beat_t'(got.size()), beat_t'(12));
    for (int j = 0; j < 12 && j < got.size(); j++)
      chk($sformatf("replay_addr%0d", j), beat_t'(got[j][KW-1:0] / 4), beat_t'(ord[j]));

    // Partial banks
    do_start(1, 0, 0, 3);
    run(1, 1, 100, 100, 1, 100);
    chk("partial_n", beat_t'(got.size()), beat_t'(1));
    chk("partial_b0", got[0], mk4(0, 102, 101, 100));

    // Ping-pong, back to back
    do_start(2, 1, 4, 4);
    run(2, 40, 100, 100, 0, 0);
    chk("pp_n", beat_t'(got_cyc.size()), beat_t'(40));
    if (got_cyc.size() == 40) chk("pp_gap", beat_t'(got_cyc[39] - got_cyc[0]), beat_t'(39));

    // Random configs and handshakes
    for (int it = 0; it < 6; it++) begin
      int l = $urandom_range(8, 1), d = $urandom_range(3, 0), m = $urandom_range(3, 0);
      int a = $urandom_range(NB, 1);
      do_start(l, d, m, a);
      run(3, 3 * l * (m + 1) * (d + 1), 60, 50, 0, 0);
    end
    mon_en = 0;

    // Config errors and the legal WPB boundary
    start_cfg(2, 1, 0, 0);
    chk("err_act0", beat_t'(err_o), beat_t'(1));
    chk("err_act0_busy", beat_t'(busy_o), '0);
    @(posedge clk); #1;
    chk("err_act0_wr_ready", beat_t'(wr_ready_o), '0);
    start_cfg(2, 1, 0, 5);
    chk("err_act5", beat_t'(err_o), beat_t'(1));
    start_cfg(0, 1, 0, 4);
    chk("err_lim0", beat_t'(err_o), beat_t'(1));
    start_cfg(64, 2, 0, 4);
    chk("err_wpb192", beat_t'(err_o), beat_t'(1));
    start_cfg(64, 1, 0, 4);
    chk("ok_wpb128_err", beat_t'(err_o), '0);
    chk("ok_wpb128_busy", beat_t'(busy_o), beat_t'(1));

    // Abort by start with a beat accepted on the same edge
    do_start(2, 1, 0, 4);
    run(1, 0, 100, 0, 1, 0);
    mon_en = 0;
    kerl_req_i = 1; start_i = 1;
    @(posedge clk); #1;
    start_i = 0; kerl_req_i = 0;
    chk("abort_valid", beat_t'(kerl_valid_o), '0);
    chk("abort_kerl_ready", beat_t'(kerl_ready_o), '0);
    chk("abort_wr_ready", beat_t'(wr_ready_o), '0);
    chk("abort_data", kerl_data_o, '0);

    // Abort by reset with a beat in flight
    do_start(2, 1, 0, 4);
    run(1, 0, 100, 0, 1, 0);
    mon_en = 0;
    kerl_req_i = 1;
    @(posedge clk); #1;
    kerl_req_i = 0; rst = 1;
    #1;
    chk("rst_abort_valid", beat_t'(kerl_valid_o), '0);
    chk("rst_abort_kerl_ready", beat_t'(kerl_ready_o), '0);
    chk("rst_abort_wr_ready", beat_t'(wr_ready_o), '0);
    chk("rst_abort_busy", beat_t'(busy_o), '0);
    chk("rst_abort_data", kerl_data_o, '0);
    @(posedge clk); #1 rst = 0;

    // Recovery after reset
    do_start(2, 1, 0, 4);
    run(1, 4, 100, 100, 1, 0);
    chk("recover_b0", got[0], mk4(3, 2, 1, 0));
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
